// File: rtl/pwm_motor_decoder.sv
// Recovers the 8-level velocity code and direction bit from a motor PWM line
// and its two direction lines; strobes new_vel_o whenever the decoded command changes.

module pwm_motor_decoder_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module pwm_motor_decoder #(
  parameter int G_FREQ_CLK = 12000000,
  parameter int G_PWM_FRQ  = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_i,
  input  logic       dir1_i,
  input  logic       dir2_i,
  output logic [2:0] vel_o,
  output logic       dir_o,
  output logic       new_vel_o,
  output logic       err_o
);
  localparam int C_SLICE   = G_FREQ_CLK / (G_PWM_FRQ * 8);
  localparam int C_PERIOD  = C_SLICE * 8;
  localparam int C_TIMEOUT = C_PERIOD + C_PERIOD / 2;
  localparam int CNT_W     = $clog2(C_TIMEOUT + 1);
  localparam int SUB_W     = $clog2(C_SLICE);
  localparam int NUM_LANES = 3;
  localparam int STAGES    = 2;

  typedef struct packed {
    logic [2:0] vel;
    logic       dir;
  } cmd_t;

  logic [NUM_LANES-1:0] in_raw, in_s;
  logic                 pwm_s, d1_s, d2_s, pwm_d;
  logic [STAGES:0]      vld_pipe;
  logic [CNT_W-1:0]     period_cnt;
  logic [SUB_W-1:0]     sub_cnt;
  logic [2:0]           hi_slices;
  logic                 have_edge;
  logic                 rise, timeout, dir_ok;
  logic                 do_commit, upd, err_nxt;
  cmd_t                 cur, meas;

  assign in_raw = {dir2_i, dir1_i, pwm_i};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_sync
    pwm_motor_decoder_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (in_raw[g]),
      .q     (in_s[g])
    );
  end

  assign pwm_s = in_s[0];
  assign d1_s  = in_s[1];
  assign d2_s  = in_s[2];

  // vld_pipe marks when pwm_d holds a real sample, so a line that is already
  // high at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      pwm_d    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      pwm_d    <= pwm_s;
    end
  end

  assign rise    = pwm_s & ~pwm_d & vld_pipe[STAGES];
  assign timeout = ~rise & (period_cnt == CNT_W'(C_TIMEOUT - 1));
  assign dir_ok  = d1_s ^ d2_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  period_cnt <= '0;
    else if (rise || timeout)                    period_cnt <= '0;
    else if (period_cnt != CNT_W'(C_TIMEOUT))    period_cnt <= period_cnt + 1'b1;
  end

  // The rise cycle is itself a high cycle, hence the half-slice bias plus one:
  // hi_slices ends at floor((H + C_SLICE/2) / C_SLICE), saturated at 7.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt   <= '0;
      hi_slices <= '0;
    end else if (rise) begin
      sub_cnt   <= SUB_W'(C_SLICE / 2 + 1);
      hi_slices <= '0;
    end else if (pwm_s) begin
      if (sub_cnt == SUB_W'(C_SLICE - 1)) begin
        sub_cnt <= '0;
        if (hi_slices != 3'd7) hi_slices <= hi_slices + 3'd1;
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    meas.vel  = hi_slices;
    meas.dir  = dir_ok ? d2_s : cur.dir;
    do_commit = 1'b0;
    err_nxt   = err_o;
    if (rise) begin
      if (have_edge) begin
        do_commit = 1'b1;
        err_nxt   = ~dir_ok;
      end
    end else if (timeout) begin
      if (pwm_s) begin
        err_nxt = 1'b1;
      end else begin
        do_commit = 1'b1;
        meas.vel  = 3'd0;
        err_nxt   = ~dir_ok;
      end
    end
  end

  assign upd = do_commit && (meas != cur);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= '0;
      new_vel_o <= 1'b0;
      err_o     <= 1'b0;
      have_edge <= 1'b0;
    end else begin
      new_vel_o <= upd;
      err_o     <= err_nxt;
      if (upd)          cur       <= meas;
      if (rise)         have_edge <= 1'b1;
      else if (timeout) have_edge <= 1'b0;
    end
  end

  assign vel_o = cur.vel;
  assign dir_o = cur.dir;
endmodule
